// File: rtl/adap_scale_factor_if.sv
// Sample-update handshake between the ADPCM decoder control and the scale
// factor adaptation stage.
interface adap_scale_factor_if;
  logic        upd;
  logic [4:0]  i;
  logic [1:0]  rate;
  logic [6:0]  al;
  logic [12:0] y;
  logic        y_valid;
  logic        busy;

  modport master (
    output upd, i, rate, al,
    input  y, y_valid, busy
  );

  modport slave (
    input  upd, i, rate, al,
    output y, y_valid, busy
  );
endinterface

// File: rtl/adap_scale_factor.sv
// G.726 scale factor adaptation (FUNCTW, FILTD, LIMB, FILTE, MIX) holding the
// fast/slow scale factors and producing the quantizer scale factor y.
module adap_scale_factor #(
  parameter logic [12:0] YU_RST = 13'd544,
  parameter logic [12:0] YU_MAX = 13'd5120,
  parameter logic [18:0] YL_RST = 19'd34816
) (
  input  logic               clk,
  input  logic               rst_n,
  adap_scale_factor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_SETTLE
  } state_t;

  state_t      state_reg;
  logic [4:0]  code_reg;
  logic [1:0]  rate_reg;
  logic [12:0] yu_reg;
  logic [18:0] yl_reg;
  logic [12:0] y_reg;
  logic        y_valid_reg;
  logic        busy_reg;

  // ---------------------------------------------------------------- FUNCTW
  function automatic logic signed [11:0] w_40k(input logic [3:0] idx);
    logic signed [11:0] w;
    case (idx)
      4'd0:    w = 12'sd14;
      4'd1:    w = 12'sd14;
      4'd2:    w = 12'sd24;
      4'd3:    w = 12'sd39;
      4'd4:    w = 12'sd40;
      4'd5:    w = 12'sd41;
      4'd6:    w = 12'sd58;
      4'd7:    w = 12'sd100;
      4'd8:    w = 12'sd141;
      4'd9:    w = 12'sd179;
      4'd10:   w = 12'sd219;
      4'd11:   w = 12'sd280;
      4'd12:   w = 12'sd358;
      4'd13:   w = 12'sd440;
      4'd14:   w = 12'sd529;
      default: w = 12'sd696;
    endcase
    return w;
  endfunction

  function automatic logic signed [11:0] w_32k(input logic [2:0] idx);
    logic signed [11:0] w;
    case (idx)
      3'd0:    w = -12'sd12;
      3'd1:    w = 12'sd18;
      3'd2:    w = 12'sd41;
      3'd3:    w = 12'sd64;
      3'd4:    w = 12'sd112;
      3'd5:    w = 12'sd198;
      3'd6:    w = 12'sd355;
      default: w = 12'sd1122;
    endcase
    return w;
  endfunction

  function automatic logic signed [11:0] w_24k(input logic [1:0] idx);
    logic signed [11:0] w;
    case (idx)
      2'd0:    w = -12'sd4;
      2'd1:    w = 12'sd30;
      2'd2:    w = 12'sd137;
      default: w = 12'sd582;
    endcase
    return w;
  endfunction

  // Negative codes fold onto the same magnitude index by one's complement.
  logic signed [11:0] w_next;
  always_comb begin
    w_next = '0;
    case (rate_reg)
      2'd0: w_next = w_40k(code_reg[4] ? ~code_reg[3:0] : code_reg[3:0]);
      2'd1: w_next = w_32k(code_reg[3] ? ~code_reg[2:0] : code_reg[2:0]);
      2'd2: w_next = w_24k(code_reg[2] ? ~code_reg[1:0] : code_reg[1:0]);
      default: w_next = (code_reg[1] ^ code_reg[0]) ? 12'sd439 : -12'sd22;
    endcase
  end

  // ----------------------------------------------------------- FILTD / LIMB
  logic [16:0] filtd_dif;
  logic [12:0] filtd_difsx;
  logic [12:0] yut;
  logic [12:0] yu_next;

  assign filtd_dif   = {w_next, 5'b0} - {4'b0, y_reg};
  // Arithmetic shift right by 5: the sign bit refills the top position.
  assign filtd_difsx = {filtd_dif[16], filtd_dif[16:5]};
  assign yut         = y_reg + filtd_difsx;

  always_comb begin
    yu_next = yut;
    if (yut < YU_RST)
      yu_next = YU_RST;
    else if (yut > YU_MAX)
      yu_next = YU_MAX;
  end

  // ------------------------------------------------------------------ FILTE
  logic [20:0] yl_comp;
  logic [13:0] filte_dif;
  logic [18:0] yl_next;

  assign yl_comp   = 21'd1048576 - {2'b0, yl_reg};
  assign filte_dif = {1'b0, yu_next} + yl_comp[19:6];
  assign yl_next   = yl_reg + {{5{filte_dif[13]}}, filte_dif};

  // -------------------------------------------------------------------- MIX
  logic [12:0] yl_int;
  logic [13:0] mix_dif;
  logic [13:0] mix_neg;
  logic [12:0] mix_difm;
  logic [19:0] mix_full;
  logic [13:0] mix_prodm;
  logic [13:0] mix_prod;
  logic [12:0] y_next;

  assign yl_int    = yl_reg[18:6];
  assign mix_dif   = {1'b0, yu_reg} - {1'b0, yl_int};
  assign mix_neg   = 14'd0 - mix_dif;
  assign mix_difm  = mix_dif[13] ? mix_neg[12:0] : mix_dif[12:0];
  assign mix_full  = {7'b0, mix_difm} * {13'b0, bus.al};
  assign mix_prodm = mix_full[19:6];
  assign mix_prod  = mix_dif[13] ? (14'd0 - mix_prodm) : mix_prodm;
  assign y_next    = yl_int + mix_prod[12:0];

  logic unused_bits;
  assign unused_bits = ^{filtd_dif[4:0], yl_comp[20], yl_comp[5:0],
                         mix_neg[13], mix_full[5:0], mix_prod[13]};

  // --------------------------------------------------------- state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      code_reg    <= '0;
      rate_reg    <= '0;
      yu_reg      <= YU_RST;
      yl_reg      <= YL_RST;
      y_reg       <= YU_RST;
      y_valid_reg <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          y_reg <= y_next;
          if (bus.upd) begin
            code_reg    <= bus.i;
            rate_reg    <= bus.rate;
            busy_reg    <= 1'b1;
            y_valid_reg <= 1'b0;
            state_reg   <= ST_UPDATE;
          end
        end
        // y_reg is held here because FILTD consumes it.
        ST_UPDATE: begin
          yu_reg    <= yu_next;
          yl_reg    <= yl_next;
          state_reg <= ST_SETTLE;
        end
        ST_SETTLE: begin
          y_reg       <= y_next;
          busy_reg    <= 1'b0;
          y_valid_reg <= 1'b1;
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.y       = y_reg;
  assign bus.y_valid = y_valid_reg;
  assign bus.busy    = busy_reg;

endmodule

// File: tb/tb_adap_scale_factor.sv
// Directed and randomized checks of adap_scale_factor against an integer
// model of the G.726 scale factor adaptation equations.
module tb_adap_scale_factor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adap_scale_factor_if bus();

  adap_scale_factor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int m_yu = 544;
  int m_yl = 34816;

  int w40[16] = '{14, 14, 24, 39, 40, 41, 58, 100, 141, 179, 219, 280, 358, 440, 529, 696};
  int w32[8]  = '{-12, 18, 41, 64, 112, 198, 355, 1122};
  int w24[4]  = '{-4, 30, 137, 582};
  int w16[2]  = '{-22, 439};

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_mix(input int yu, input int yl, input int al);
    int yl6, dif, difm, prodm, prod;
    yl6 = yl >> 6;
    dif = (yu + 16384 - yl6) % 16384;
    difm = (dif >= 8192) ? (16384 - dif) % 8192 : dif;
    prodm = (difm * al) >> 6;
    prod = (dif >= 8192) ? (16384 - prodm) % 16384 : prodm;
    return (yl6 + prod) % 8192;
  endfunction

  function automatic int model_w(input int code, input int rate);
    int width, c, idx;
    width = 5 - rate;
    c = code % (1 << width);
    idx = ((c >> (width - 1)) != 0) ? ((1 << width) - 1 - c) : c;
    case (rate)
      0: return w40[idx];
      1: return w32[idx];
      2: return w24[idx];
      default: return w16[idx];
    endcase
  endfunction

  task automatic model_update(input int code, input int rate, input int y_now);
    int w, dif, difsx, yut, yu_new, dl;
    w = model_w(code, rate);
    dif = (w * 32 + 131072 - y_now) % 131072;
    difsx = (dif >= 65536) ? (dif >> 5) + 4096 : (dif >> 5);
    yut = (y_now + difsx) % 8192;
    yu_new = (yut < 544) ? 544 : ((yut > 5120) ? 5120 : yut);
    dl = (yu_new + ((1048576 - m_yl) >> 6)) % 16384;
    m_yl = (m_yl + ((dl >= 8192) ? dl + 507904 : dl)) % 524288;
    m_yu = yu_new;
  endtask

  task automatic do_reset(input int al);
    rst_n = 1'b0;
    bus.upd = 1'b0;
    bus.al = 7'(al);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_yu = 544;
    m_yl = 34816;
    check("reset_y", int'(bus.y), 544);
    check("reset_valid", int'(bus.y_valid), 1);
    check("reset_busy", int'(bus.busy), 0);
  endtask

  task automatic set_al(input int al);
    bus.al = 7'(al);
    @(negedge clk);
    check("idle_valid", int'(bus.y_valid), 1);
    check("idle_y", int'(bus.y), model_mix(m_yu, m_yl, al));
  endtask

  // Entered and left on a falling edge; hold keeps upd high (with a different
  // code) through the busy cycles, which must be ignored.
  task automatic do_update(input int code, input int rate, input int al, input bit hold);
    int y_used;
    bus.upd = 1'b1;
    bus.i = 5'(code);
    bus.rate = 2'(rate);
    bus.al = 7'(al);
    @(negedge clk);
    if (hold) bus.i = 5'(code ^ 5'h1f);
    else bus.upd = 1'b0;
    check("capture_busy", int'(bus.busy), 1);
    check("capture_valid", int'(bus.y_valid), 0);
    y_used = model_mix(m_yu, m_yl, al);
    model_update(code, rate, y_used);
    @(negedge clk);
    check("update_busy", int'(bus.busy), 1);
    @(negedge clk);
    bus.upd = 1'b0;
    check("done_valid", int'(bus.y_valid), 1);
    check("done_busy", int'(bus.busy), 0);
    check("done_y", int'(bus.y), model_mix(m_yu, m_yl, al));
    $display("update rate=%0d i=%0d al=%0d hold=%0d -> y=%0d (model %0d)",
             rate, code, al, hold, bus.y, model_mix(m_yu, m_yl, al));
  endtask

  initial begin
    int prev_y, code, rate, al;
    bus.upd = 1'b0;
    bus.i = '0;
    bus.rate = '0;
    bus.al = 7'd37;
    @(negedge clk);

    // Reset state and idle hold
    do_reset(37);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_hold_y", int'(bus.y), 544);
    end

    // 32k, I=7 at full speed control, then AL=0 exposes YL
    do_update(7, 1, 64, 1'b0);
    check("first_update_y", int'(bus.y), 1649);
    set_al(0);
    check("al0_y", int'(bus.y), 561);

    // Lower clamp and 16k table
    do_reset(64);
    do_update(0, 1, 64, 1'b0);
    check("limb_floor_y", int'(bus.y), 544);
    do_reset(64);
    do_update(1, 3, 64, 1'b0);
    check("rate16_y", int'(bus.y), 966);

    // Saturation at the ceiling, with ignored strobes during busy
    do_reset(64);
    prev_y = 544;
    for (int k = 0; k < 10; k++) begin
      do_update(7, 1, 64, k[0]);
      check("sat_monotonic", int'(int'(bus.y) >= prev_y), 1);
      check("sat_ceiling", int'(int'(bus.y) <= 5120), 1);
      prev_y = int'(bus.y);
    end
    check("sat_final", int'(bus.y), 5120);

    // Reset landing on the UPDATE cycle discards the captured code
    do_reset(20);
    bus.upd = 1'b1;
    bus.i = 5'd7;
    bus.rate = 2'd1;
    @(negedge clk);
    bus.upd = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_yu = 544;
    m_yl = 34816;
    check("midreset_y", int'(bus.y), 544);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_valid", int'(bus.y_valid), 1);
    set_al(0);
    set_al(64);

    // Randomized updates across rates, codes and AL (including AL > 64)
    do_reset(int'($urandom_range(0, 64)));
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) set_al(int'($urandom_range(0, 64)));
      code = int'($urandom_range(0, 31));
      rate = int'($urandom_range(0, 3));
      al = ($urandom_range(0, 7) == 0) ? int'($urandom_range(65, 127))
                                       : int'($urandom_range(0, 64));
      do_update(code, rate, al, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/adap_scale_factor.md
Name: adap_scale_factor

Overview:
- Scale factor adaptation stage of the G.726 ADPCM decoder (FUNCTW, FILTD, LIMB, DELAY, FILTE, MIX).
- Sits directly upstream of the inverse adaptive quantizer and supplies its 13-bit Y input.
- Holds the fast (YU) and slow (YL) scale factor state.
- Once per sample, consumes the received code I, then updates YU and YL and recomputes Y for the next sample.

Parameters:
- YU_RST, 544, reset and lower limit of YU (LIMB floor).
- YU_MAX, 5120, upper limit of YU (LIMB ceiling).
- YL_RST, 34816, reset value of YL (19-bit; equals 544 in the 2^-6 domain).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- UPD  in  1  one-cycle sample-update strobe; qualifies I and RATE.
- I  in  5  received ADPCM code, LSB-aligned (5/4/3/2 valid bits for 40/32/24/16 kbit/s).
- RATE  in  2  0=40k, 1=32k, 2=24k, 3=16k.
- AL  in  7  speed-control coefficient, unsigned, 0..64.
- Y  out  13  quantizer scale factor, registered.
- Y_VALID  out  1  Y is consistent with current YU, YL and AL.
- BUSY  out  1  update in progress; UPD is ignored while high.

Behaviour:
- Reset (RST_N=0 at an edge):
  - YU=544, YL=34816, Y=544, Y_VALID=1, BUSY=0, FSM=IDLE.
  - Reset applies mid-update too, discarding any captured I.
  - Y=544 is exact for any AL because YU-(YL>>6)=0.
- FSM has three states, IDLE, UPDATE and SETTLE:
  - IDLE & UPD: capture I and RATE, go to UPDATE, BUSY=1, Y_VALID=0.
  - UPDATE: write new YU and YL from the captured code and the current Y register, go to SETTLE.
  - SETTLE: Y <= MIX(YU, YL, AL), go to IDLE.
  - Y_VALID=1 and BUSY=0 from the cycle after SETTLE.
  - Latency from the UPD edge to Y_VALID high is 3 cycles.
  - Back-to-back UPD is accepted at most every 3 cycles.
- Outside UPDATE, the Y register reloads MIX(YU, YL, AL) every cycle.
  - A change on AL is reflected in Y one cycle later.
  - Y_VALID stays 1 while AL changes in IDLE.
- FUNCTW, sign and magnitude index per rate:
  - 40k: sign=I[4], idx = sign ? 31-I : I (0..15).
  - 32k: sign=I[3], idx = sign ? 15-I[3:0] : I[3:0].
  - 24k: sign=I[2], idx = sign ? 7-I[2:0] : I[2:0].
  - 16k: sign=I[1], idx = sign ? 3-I[1:0] : I[1:0].
  - Upper bits of I beyond the rate width are ignored.
- FUNCTW, W tables (decimal, 12-bit two's complement):
  - 40k: 14,14,24,39,40,41,58,100,141,179,219,280,358,440,529,696
  - 32k: -12,18,41,64,112,198,355,1122
  - 24k: -4,30,137,582
  - 16k: -22,439
- FILTD:
  - DIF = ((W<<5) + 131072 - Y) mod 2^17; DIFS = DIF[16].
  - DIFSX = DIFS ? (DIF>>5)+4096 : DIF>>5.
  - YUT = (Y + DIFSX) mod 8192.
- LIMB: YU_new = min(max(YUT, 544), 5120).
- FILTE, using YU_new:
  - DIF = (YU_new + ((1048576 - YL)>>6)) mod 16384; DIFS = DIF[13].
  - YL_new = (YL + (DIFS ? DIF+507904 : DIF)) mod 524288.
- MIX:
  - DIF = (YU + 16384 - (YL>>6)) mod 16384; DIFS = DIF[13].
  - DIFM = DIFS ? (16384-DIF) mod 8192 : DIF; PRODM = (DIFM*AL)>>6.
  - PROD = DIFS ? (16384-PRODM) mod 16384 : PRODM.
  - Y = ((YL>>6) + PROD) mod 8192.
- AL > 64 is out of range; behaviour is the formula result, with no clamping.
- All arithmetic is bit-exact against the ITU model vectors (y.t).

Test Plan:
- Reset with AL=37 -> Y=544, Y_VALID=1, BUSY=0; hold IDLE 5 cycles -> Y stays 544.
- RATE=1, I=7, AL=64, pulse UPD -> YU=1649, YL=35921; 3 cycles later Y=1649, Y_VALID=1. Then AL=0 -> Y=561 next cycle.
- RATE=1, I=0 (W=-12) from reset -> YUT=515, clamped to YU=544. RATE=3, I=1 (W=439) from reset -> YU=966.
- RATE=1, I=7, AL=64, repeated UPD -> YU rises monotonically and saturates at exactly 5120, never exceeding it. UPD pulsed during BUSY -> ignored, state advances once.
- RST_N low during the UPDATE cycle -> next cycle YU=544, YL=34816, Y=544, BUSY=0.
- Full regression for each RATE x law (dec, homing) against y.t, with I from I.t and AL from the model -> zero Y mismatches over 19879 samples.
